// File: rtl/equiv_pkg.sv
// Shared types and constant helpers for the equivalence miter checker.
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } equiv_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // All-ones value of a w-bit counter (valid for w up to 64).
  function automatic logic [63:0] sat_limit(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// Fixed-depth register delay line with asynchronous clear; depth 0 is a wire.
module equiv_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else if (DEPTH == 1) begin : g_one
      logic [WIDTH-1:0] stage_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= '0;
        else        stage_reg <= d;
      end
      assign q = stage_reg;
    end else begin : g_chain
      // Newest sample in the low slice, oldest in the top slice.
      logic [DEPTH*WIDTH-1:0] chain_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[(DEPTH-1)*WIDTH-1:0], d};
      end
      assign q = chain_reg[DEPTH*WIDTH-1 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/equiv_miter_chk.sv
// Equivalence miter: aligns two buses, masks, skips warm-up, and reports
// mismatch count plus the first failing difference.
module equiv_miter_chk
  import equiv_pkg::*;
#(
  parameter int WIDTH         = 91,
  parameter int DLY_A         = 0,
  parameter int DLY_B         = 0,
  parameter int WARMUP        = 4,
  parameter int CNT_W         = 16,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  input  logic [WIDTH-1:0] cmp_mask,
  output logic             running,
  output logic             fail,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] check_cnt,
  output logic [WIDTH-1:0] first_diff,
  output logic [CNT_W-1:0] first_cycle
);

  localparam int               D         = max2(DLY_A, DLY_B);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_limit(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam equiv_state_t     RUN_STATE = (WARMUP > 0) ? ST_WARMUP : ST_CHECK;

  logic [WIDTH-1:0] a_al;
  logic [WIDTH-1:0] b_al;
  logic [WIDTH:0]   mv_al;
  logic [WIDTH-1:0] diff;
  logic             en_al;
  logic             mism;

  equiv_delay_line #(.WIDTH(WIDTH), .DEPTH(DLY_A)) u_dly_a (
    .clk(clk), .rst_n(rst_n), .d(y_a), .q(a_al)
  );

  equiv_delay_line #(.WIDTH(WIDTH), .DEPTH(DLY_B)) u_dly_b (
    .clk(clk), .rst_n(rst_n), .d(y_b), .q(b_al)
  );

  equiv_delay_line #(.WIDTH(WIDTH + 1), .DEPTH(D)) u_dly_mv (
    .clk(clk), .rst_n(rst_n), .d({cmp_mask, valid_in}), .q(mv_al)
  );

  assign en_al = mv_al[0];
  assign diff  = (a_al ^ b_al) & mv_al[WIDTH:1];
  assign mism  = |diff;

  equiv_state_t     state_reg, state_next;
  logic [7:0]       warm_cnt_reg, warm_cnt_next;
  logic             fail_reg, fail_next;
  logic             pulse_reg, pulse_next;
  logic [CNT_W-1:0] mis_cnt_reg, mis_cnt_next;
  logic [CNT_W-1:0] chk_cnt_reg, chk_cnt_next;
  logic [WIDTH-1:0] first_diff_reg, first_diff_next;
  logic [CNT_W-1:0] first_cycle_reg, first_cycle_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      warm_cnt_reg    <= '0;
      fail_reg        <= 1'b0;
      pulse_reg       <= 1'b0;
      mis_cnt_reg     <= '0;
      chk_cnt_reg     <= '0;
      first_diff_reg  <= '0;
      first_cycle_reg <= '0;
    end else begin
      state_reg       <= state_next;
      warm_cnt_reg    <= warm_cnt_next;
      fail_reg        <= fail_next;
      pulse_reg       <= pulse_next;
      mis_cnt_reg     <= mis_cnt_next;
      chk_cnt_reg     <= chk_cnt_next;
      first_diff_reg  <= first_diff_next;
      first_cycle_reg <= first_cycle_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    warm_cnt_next    = warm_cnt_reg;
    fail_next        = fail_reg;
    pulse_next       = 1'b0;
    mis_cnt_next     = mis_cnt_reg;
    chk_cnt_next     = chk_cnt_reg;
    first_diff_next  = first_diff_reg;
    first_cycle_next = first_cycle_reg;

    // start overrides any compare happening in the same cycle.
    if (start) begin
      state_next       = RUN_STATE;
      warm_cnt_next    = '0;
      fail_next        = 1'b0;
      mis_cnt_next     = '0;
      chk_cnt_next     = '0;
      first_diff_next  = '0;
      first_cycle_next = '0;
    end else begin
      case (state_reg)
        ST_WARMUP: begin
          if (en_al) begin
            if (warm_cnt_reg == WARM_LAST) state_next = ST_CHECK;
            else                           warm_cnt_next = warm_cnt_reg + 8'd1;
          end
        end
        ST_CHECK: begin
          if (en_al) begin
            if (chk_cnt_reg != CNT_MAX) chk_cnt_next = chk_cnt_reg + CNT_ONE;
            if (mism) begin
              pulse_next = 1'b1;
              fail_next  = 1'b1;
              if (mis_cnt_reg != CNT_MAX) mis_cnt_next = mis_cnt_reg + CNT_ONE;
              if (!fail_reg) begin
                first_diff_next  = diff;
                first_cycle_next = chk_cnt_reg;
              end
              if (STOP_ON_FIRST != 0) state_next = ST_HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign running        = (state_reg == ST_WARMUP) || (state_reg == ST_CHECK);
  assign fail           = fail_reg;
  assign mismatch_pulse = pulse_reg;
  assign mismatch_cnt   = mis_cnt_reg;
  assign check_cnt      = chk_cnt_reg;
  assign first_diff     = first_diff_reg;
  assign first_cycle    = first_cycle_reg;

endmodule

// File: tb/tb_equiv_miter_chk.sv
// Random-stimulus bench for two miter configurations against a history-based
// reference model of the checker rules.
module tb_equiv_miter_chk;

  localparam int W = 91;
  typedef logic [W-1:0] w_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic valid_in = 1'b0;
  w_t   y_a = '0, yb0 = '0, yb1 = '0, cmp_mask = '0;

  logic       run0, fail0, pulse0;
  logic [3:0] mcnt0, ccnt0, fcyc0;
  w_t         fdiff0;
  logic       run1, fail1, pulse1;
  logic [7:0] mcnt1, ccnt1, fcyc1;
  w_t         fdiff1;

  always #5 clk = ~clk;

  equiv_miter_chk #(.WIDTH(W), .DLY_A(2), .DLY_B(0), .WARMUP(4), .CNT_W(4),
                    .STOP_ON_FIRST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
    .y_a(y_a), .y_b(yb0), .cmp_mask(cmp_mask),
    .running(run0), .fail(fail0), .mismatch_pulse(pulse0),
    .mismatch_cnt(mcnt0), .check_cnt(ccnt0), .first_diff(fdiff0),
    .first_cycle(fcyc0)
  );

  equiv_miter_chk #(.WIDTH(W), .DLY_A(1), .DLY_B(1), .WARMUP(0), .CNT_W(8),
                    .STOP_ON_FIRST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
    .y_a(y_a), .y_b(yb1), .cmp_mask(cmp_mask),
    .running(run1), .fail(fail1), .mismatch_pulse(pulse1),
    .mismatch_cnt(mcnt1), .check_cnt(ccnt1), .first_diff(fdiff1),
    .first_cycle(fcyc1)
  );

  // Per-instance parameters as the model sees them.
  int p_da[2] = '{2, 1};
  int p_db[2] = '{0, 1};
  int p_wu[2] = '{4, 0};
  int p_cw[2] = '{4, 8};
  int p_sf[2] = '{0, 1};

  // Input history: index k holds the value from k cycles ago (0 = now).
  w_t ha[16];
  w_t hm[16];
  bit hv[16];
  w_t hb[2][16];

  // Model status; m_st: 0 idle, 1 warm-up, 2 checking, 3 halted.
  int m_st[2], m_wc[2], m_chk[2], m_mis[2], m_fc[2];
  bit m_fail[2], m_pulse[2];
  w_t m_fd[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_wc[i] = 0; m_chk[i] = 0; m_mis[i] = 0; m_fc[i] = 0;
      m_fail[i] = 0; m_pulse[i] = 0; m_fd[i] = '0;
    end
    for (int k = 0; k < 16; k++) begin
      ha[k] = '0; hm[k] = '0; hv[k] = 0; hb[0][k] = '0; hb[1][k] = '0;
    end
  endtask

  task automatic hist_push();
    for (int k = 15; k > 0; k--) begin
      ha[k] = ha[k-1]; hm[k] = hm[k-1]; hv[k] = hv[k-1];
      hb[0][k] = hb[0][k-1]; hb[1][k] = hb[1][k-1];
    end
    ha[0] = y_a; hm[0] = cmp_mask; hv[0] = valid_in;
    hb[0][0] = yb0; hb[1][0] = yb1;
  endtask

  task automatic model_step(input int i);
    int d, mx;
    w_t dv;
    bit en;
    d  = (p_da[i] > p_db[i]) ? p_da[i] : p_db[i];
    mx = (1 << p_cw[i]) - 1;
    en = hv[d];
    dv = (ha[p_da[i]] ^ hb[i][p_db[i]]) & hm[d];
    m_pulse[i] = 0;
    if (start) begin
      m_st[i] = (p_wu[i] > 0) ? 1 : 2;
      m_wc[i] = 0; m_chk[i] = 0; m_mis[i] = 0; m_fc[i] = 0;
      m_fail[i] = 0; m_fd[i] = '0;
    end else if (m_st[i] == 1 && en) begin
      m_wc[i]++;
      if (m_wc[i] == p_wu[i]) m_st[i] = 2;
    end else if (m_st[i] == 2 && en) begin
      if (dv != '0) begin
        m_pulse[i] = 1;
        if (m_mis[i] < mx) m_mis[i]++;
        if (!m_fail[i]) begin
          m_fd[i] = dv;
          m_fc[i] = m_chk[i];
        end
        m_fail[i] = 1;
        if (p_sf[i] != 0) m_st[i] = 3;
      end
      if (m_chk[i] < mx) m_chk[i]++;
    end
  endtask

  task automatic check_all();
    chk_val("i0.running",     run0,   (m_st[0] == 1) || (m_st[0] == 2));
    chk_val("i0.fail",        fail0,  m_fail[0]);
    chk_val("i0.pulse",       pulse0, m_pulse[0]);
    chk_val("i0.mismatch_cnt", mcnt0, m_mis[0]);
    chk_val("i0.check_cnt",   ccnt0,  m_chk[0]);
    chk_val("i0.first_diff",  fdiff0, m_fd[0]);
    chk_val("i0.first_cycle", fcyc0,  m_fc[0]);
    chk_val("i1.running",     run1,   (m_st[1] == 1) || (m_st[1] == 2));
    chk_val("i1.fail",        fail1,  m_fail[1]);
    chk_val("i1.pulse",       pulse1, m_pulse[1]);
    chk_val("i1.mismatch_cnt", mcnt1, m_mis[1]);
    chk_val("i1.check_cnt",   ccnt1,  m_chk[1]);
    chk_val("i1.first_diff",  fdiff1, m_fd[1]);
    chk_val("i1.first_cycle", fcyc1,  m_fc[1]);
  endtask

  function automatic w_t rand_w();
    return w_t'({$urandom, $urandom, $urandom});
  endfunction

  function automatic w_t rand_flip();
    w_t f;
    int b;
    f = '0;
    if ($urandom % 3 == 0)      b = 5;
    else if ($urandom % 3 == 0) b = 90;
    else                        b = int'($urandom % W);
    f[b] = 1'b1;
    return f;
  endfunction

  initial begin
    w_t prev1, prev2, f0, f1;
    int mode;
    bit do_rst;
    prev1 = '0; prev2 = '0; mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (cyc % 60 == 0) mode = int'($urandom % 4);
      start    = (cyc == 0) || ($urandom % 50 == 0);
      valid_in = ($urandom % 4) != 0;
      prev2 = prev1;
      prev1 = y_a;
      y_a   = rand_w();
      f0 = '0; f1 = '0;
      case (mode)
        1: begin
          if ($urandom % 8 == 0)  f0 = rand_flip();
          if ($urandom % 16 == 0) f1 = rand_flip();
        end
        2: begin f0 = rand_flip(); f1 = rand_flip(); end
        3: begin
          if ($urandom % 4 == 0) f0 = rand_flip();
          if ($urandom % 4 == 0) f1 = rand_flip();
        end
        default: ;
      endcase
      yb0 = prev2 ^ f0;
      yb1 = y_a ^ f1;
      if (mode == 3)             cmp_mask = rand_w();
      else if ($urandom % 5 == 0) begin cmp_mask = '1; cmp_mask[90] = 1'b0; end
      else                       cmp_mask = '1;

      do_rst = ($urandom % 400 == 0);
      if (do_rst) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
      end

      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        hist_push();
        model_step(0);
        model_step(1);
      end
      #1 check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/equiv_miter_chk.md
# equiv_miter_chk

Parametrised equivalence miter checker sitting between two implementations of the same design (e.g. two synthesis results driven by identical stimulus) in a formal/simulation equivalence harness. It aligns the two output buses for differing pipeline latencies, applies a compare mask, and ignores a warm-up window after start. Each mismatch is counted, and the first mismatch is captured. It replaces the bare per-cycle `y_1 == y_2` assertion with a status-reporting block, plus an optional stop-on-first-failure mode.

## Interface
- WIDTH, 91 — compared bus width.
- DLY_A, 0 — extra delay stages applied to y_a (0..15).
- DLY_B, 0 — extra delay stages applied to y_b (0..15).
- WARMUP, 4 — number of compare-enabled cycles ignored after start (0..255).
- CNT_W, 16 — width of all counters.
- STOP_ON_FIRST, 0 — 1: halt checking on first mismatch.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears status and begins a check run.
- valid_in  in  1  current y_a/y_b cycle is a comparable sample.
- y_a  in  WIDTH  output of implementation A.
- y_b  in  WIDTH  output of implementation B.
- cmp_mask  in  WIDTH  1 = bit is compared; sampled with the aligned data.
- running  out  1  state is WARMUP or CHECK.
- fail  out  1  sticky; at least one mismatch since start.
- mismatch_pulse  out  1  one cycle per mismatching compare.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- check_cnt  out  CNT_W  saturating count of compares performed in CHECK.
- first_diff  out  WIDTH  masked XOR (y_a ^ y_b) & mask of first mismatch.
- first_cycle  out  CNT_W  check_cnt value at first mismatch (0-based).

## Operation
- Alignment:
  - y_a passes through DLY_A register stages; y_b passes through DLY_B stages.
  - A depth of 0 is a pass-through.
  - Delay lines shift every clock, independent of state.
- Compare enable:
  - Enable is valid_in delayed by D = max(DLY_A, DLY_B) stages.
  - cmp_mask is delayed by D as well.
- Mismatch: a compare-enabled cycle with ((a_al ^ b_al) & mask_al) != 0.
- States (encoded in package):
  - IDLE: reset state. No compares. start → WARMUP, or → CHECK if WARMUP==0.
  - WARMUP: counts compare-enabled cycles. After WARMUP of them → CHECK. Mismatches are ignored.
  - CHECK: every compare-enabled cycle increments check_cnt.
    - On mismatch: mismatch_pulse=1, mismatch_cnt++, fail=1.
    - If fail was 0 before this mismatch: latch first_diff and first_cycle.
    - If STOP_ON_FIRST=1: → HALT.
  - HALT: no compares; all status held. start → restart.
- start in any state:
  - Clears fail, counters, first_diff and first_cycle.
  - Re-enters WARMUP (or CHECK if WARMUP==0).
  - Delay-line contents are not flushed.
- Counters saturate at 2^CNT_W−1 and never wrap.
- The first mismatch after saturation still sets fail if it is clear.
- Reset values: running=0, fail=0, mismatch_pulse=0, all counters 0, first_diff=0, first_cycle=0, state IDLE, delay lines 0.

## Timing
- Latency: a sample pair whose later member enters at cycle t produces mismatch_pulse and counter updates visible at cycle t+D+1. There is one registered compare stage.
- running rises the cycle after start.
- start coinciding with a mismatch: start wins. The mismatch is discarded and all status is cleared.
- Compare at the last WARMUP cycle: not checked. The first CHECK compare is the next enabled one.
- rst_n assertion mid-run: immediate return to reset values, including delay lines.
- valid_in low: no state-counter progress in WARMUP or CHECK.

## Structure
- Package equiv_pkg holds:
  - the state enum (IDLE, WARMUP, CHECK, HALT);
  - the max function used for D;
  - the counter saturation constant helper.
- Sub-module equiv_delay_line (params WIDTH, DEPTH) is used for:
  - y_a (WIDTH, DLY_A);
  - y_b (WIDTH, DLY_B);
  - the combined {mask, valid} path (WIDTH+1, D).
- The harness top instantiates both implementations and this checker. Formal flows assert !fail.

## Test plan
- Identical buses, DLY_A=DLY_B=0, WARMUP=4, 20 valid cycles after start → fail=0, check_cnt=16, mismatch_cnt=0.
- DLY_A=2, DLY_B=0, y_b fed y_a delayed by 2 externally, WARMUP=0 → no mismatch; y_b bit 5 flipped at check index 7 → mismatch_pulse at t+3, first_diff=0x20, first_cycle=7.
- Bit 90 flipped with cmp_mask[90]=0 → no mismatch; same flip with mask bit set → fail=1.
- STOP_ON_FIRST=1, mismatches at indices 3 and 5 → state HALT after index 3, mismatch_cnt=1, check_cnt=4, running=0.
- CNT_W=4, continuous mismatch for 20 compares → mismatch_cnt saturates at 15, first_cycle=0; start pulse → all status 0.
- rst_n low during CHECK with fail=1 → all outputs 0 asynchronously; start after release → WARMUP resumes normally.
